// File: rtl/mm_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mm_dmem_responder
// Purpose  : MM2017 data-memory responder. Word-addressed load/store with
//            valid/ready request and response channels and programmable wait
//            states. Define MM_DMEM_PORT_EN to map an output port at PORT_ADDR.
// Revision : 1.0 - initial release
// ============================================================================
module mm_dmem_responder #(
  parameter int          DEPTH       = 128,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [63:0] PORT_ADDR   = 64'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] port_out,
  output logic        port_strobe
);

  localparam int          c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [63:0] c_DEPTH = 64'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [63:0]         r_addr;
  logic [63:0]         r_wdata;
  logic [63:0]         r_rdata;
  logic                r_err;
  logic [63:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_commit;
  logic                w_c_we;
  logic [63:0]         w_c_addr;
  logic [63:0]         w_c_wdata;
  logic                w_in_range;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_port_hit;
  logic [63:0]         w_port_rd;
  logic                w_mem_we;
  logic [63:0]         w_load_data;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // With zero wait states the commit happens on the accepting edge, so the
  // operands come straight from the request inputs rather than the latches.
  assign w_commit  = ((r_state == S_WAIT) && (r_cnt <= 4'd1)) ||
                     (w_accept && (WAIT_CYCLES == 0));
  assign w_c_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_c_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_in_range = (w_c_addr < c_DEPTH);
  assign w_idx      = w_c_addr[c_IDX_W-1:0];
  assign w_mem_we   = w_commit && w_c_we && w_in_range && !w_port_hit;

  always_comb begin
    w_load_data = 64'd0;
    if (!w_c_we) begin
      if (w_port_hit) begin
        w_load_data = w_port_rd;
      end else if (w_in_range) begin
        w_load_data = r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_WAIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_commit) begin
        r_rdata <= w_load_data;
        r_err   <= !w_in_range && !w_port_hit;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rdata <= 64'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Backing store is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_c_wdata;
    end
  end

`ifdef MM_DMEM_PORT_EN
  logic [63:0] r_port_out;
  logic        r_port_strobe;

  assign w_port_hit = (w_c_addr == PORT_ADDR);
  assign w_port_rd  = r_port_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_port_out    <= 64'd0;
      r_port_strobe <= 1'b0;
    end else begin
      r_port_strobe <= w_commit && w_c_we && w_port_hit;
      if (w_commit && w_c_we && w_port_hit) begin
        r_port_out <= w_c_wdata;
      end
    end
  end

  assign port_out    = r_port_out;
  assign port_strobe = r_port_strobe;
`else
  // Without the port, PORT_ADDR is just an ordinary memory word.
  assign w_port_hit  = (w_c_addr == PORT_ADDR) && 1'b0;
  assign w_port_rd   = 64'd0;
  assign port_out    = 64'd0;
  assign port_strobe = 1'b0;
`endif

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mm_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_dmem_responder
// Purpose  : Self-checking bench for mm_dmem_responder (WAIT_CYCLES=2 and 0
//            instances) against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_dmem_responder;

  localparam int DEPTH = 128;
`ifdef MM_DMEM_PORT_EN
  localparam bit PORT_EN = 1'b1;
`else
  localparam bit PORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;
  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic [63:0] rsp_rdata_a, rsp_rdata_b;
  logic        rsp_err_a, rsp_err_b;
  logic [63:0] port_out_a, port_out_b;
  logic        port_strobe_a, port_strobe_b;

  always #5 clk = ~clk;

  mm_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .PORT_ADDR(64'h3F)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .port_out(port_out_a), .port_strobe(port_strobe_a));

  mm_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .PORT_ADDR(64'h3F)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .port_out(port_out_b), .port_strobe(port_strobe_b));

  int          which;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err, cur_strobe;
  logic [63:0] cur_rdata, cur_port;

  always_comb begin
    cur_req_ready = (which == 1) ? req_ready_b   : req_ready_a;
    cur_rsp_valid = (which == 1) ? rsp_valid_b   : rsp_valid_a;
    cur_rsp_err   = (which == 1) ? rsp_err_b     : rsp_err_a;
    cur_strobe    = (which == 1) ? port_strobe_b : port_strobe_a;
    cur_rdata     = (which == 1) ? rsp_rdata_b   : rsp_rdata_a;
    cur_port      = (which == 1) ? port_out_b    : port_out_a;
  end

  // Reference model: one word array and one port register per instance.
  logic [63:0] mdl_mem [2][DEPTH];
  logic [63:0] mdl_port [2];
  int          waits [2] = '{2, 0};
  int          total  = 0;
  int          passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void model(input int d, input bit we, input logic [63:0] a,
                                input logic [63:0] wd, output logic [63:0] rd,
                                output bit err, output bit strobe);
    bit port_hit;
    port_hit = PORT_EN && (a == 64'h3F);
    rd = 64'd0; err = 1'b0; strobe = 1'b0;
    if (port_hit) begin
      if (we) begin mdl_port[d] = wd; strobe = 1'b1; end
      else rd = mdl_port[d];
    end else if (a >= 64'(DEPTH)) begin
      err = 1'b1;
    end else if (we) begin
      mdl_mem[d][a[6:0]] = wd;
    end else begin
      rd = mdl_mem[d][a[6:0]];
    end
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d == 0) req_valid_a = v; else req_valid_b = v;
  endtask

  task automatic txn(input int d, input bit we, input logic [63:0] a,
                     input logic [63:0] wd, input int stall);
    logic [63:0] erd, held;
    bit          eerr, estb;
    int          n;
    which = d;
    @(negedge clk);
    rsp_ready = (stall == 0);
    req_we = we; req_addr = a; req_wdata = wd;
    set_valid(d, 1'b1);
    chk("req_ready_idle", 64'(cur_req_ready), 64'd1);
    @(posedge clk); #1;
    set_valid(d, 1'b0);
    req_we = $urandom_range(0, 1); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    model(d, we, a, wd, erd, eerr, estb);
    n = 0;
    while (!cur_rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_latency", 64'(n + 1), 64'(waits[d] + 1));
    chk("rsp_rdata", cur_rdata, erd);
    chk("rsp_err", 64'(cur_rsp_err), 64'(eerr));
    chk("port_strobe", 64'(cur_strobe), 64'(estb));
    chk("req_ready_busy", 64'(cur_req_ready), 64'd0);
    held = cur_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(cur_rsp_valid), 64'd1);
      chk("bp_rdata", cur_rdata, held);
      chk("bp_req_ready", 64'(cur_req_ready), 64'd0);
      chk("bp_strobe", 64'(cur_strobe), 64'd0);
    end
    if (stall > 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_valid", 64'(cur_rsp_valid), 64'd0);
    chk("post_rdata", cur_rdata, 64'd0);
    chk("post_err", 64'(cur_rsp_err), 64'd0);
    chk("post_req_ready", 64'(cur_req_ready), 64'd1);
    chk("port_out", cur_port, mdl_port[d]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready_a"}, 64'(req_ready_a), 64'd1);
    chk({tag, "_rsp_valid_a"}, 64'(rsp_valid_a), 64'd0);
    chk({tag, "_rsp_rdata_a"}, rsp_rdata_a, 64'd0);
    chk({tag, "_rsp_err_a"}, 64'(rsp_err_a), 64'd0);
    chk({tag, "_port_out_a"}, port_out_a, 64'd0);
    chk({tag, "_strobe_a"}, 64'(port_strobe_a), 64'd0);
    chk({tag, "_req_ready_b"}, 64'(req_ready_b), 64'd1);
    chk({tag, "_port_out_b"}, port_out_b, 64'd0);
  endtask

  initial begin
    int          acc;
    logic [63:0] a;
    which = 0;
    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    mdl_port[0] = 64'd0; mdl_port[1] = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // Fill both stores so every later load has a defined expectation.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        txn(d, 1'b1, 64'(i), {$urandom, $urandom}, 0);

    txn(0, 1'b1, 64'd5, 64'hDEAD_BEEF_0123_4567, 0);
    txn(0, 1'b0, 64'd5, 64'd0, 0);
    chk("load5_model", mdl_mem[0][5], 64'hDEAD_BEEF_0123_4567);

    txn(0, 1'b0, 64'd128, 64'd0, 0);
    txn(0, 1'b1, 64'd72, 64'h7272_7272_7272_7272, 0);
    txn(0, 1'b1, 64'd200, 64'hBAD0_BAD0_BAD0_BAD0, 0);
    txn(0, 1'b0, 64'd72, 64'd0, 0);
    txn(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    txn(0, 1'b0, 64'h8000_0000_0000_0005, 64'd0, 2);

    txn(0, 1'b0, 64'd17, 64'd0, 5);

    // Reset while the store to address 9 is still waiting.
    txn(0, 1'b1, 64'd9, 64'h0123_0000_0000_0009, 0);
    which = 0;
    @(negedge clk);
    rsp_ready = 1'b0; req_we = 1'b1; req_addr = 64'd9; req_wdata = 64'h55;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    mdl_port[0] = 64'd0; mdl_port[1] = 64'd0;
    chk_reset_outputs("midwait_rst");
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    txn(0, 1'b0, 64'd9, 64'd0, 0);

    txn(0, 1'b1, 64'd63, 64'h3F, 0);
    chk("port_after_store", port_out_a, PORT_EN ? 64'h3F : 64'd0);
    txn(0, 1'b0, 64'd63, 64'd0, 0);
    txn(1, 1'b1, 64'd63, 64'h1234, 3);
    txn(1, 1'b0, 64'd63, 64'd0, 0);

    txn(1, 1'b1, 64'd100, 64'hCAFE_F00D_0000_0100, 0);
    txn(1, 1'b0, 64'd100, 64'd0, 0);
    txn(1, 1'b0, 64'd300, 64'd0, 2);

    // Zero wait states with rsp_ready held high: one accept every two cycles.
    which = 1;
    @(negedge clk);
    rsp_ready = 1'b1; req_we = 1'b0; req_addr = 64'd3; req_valid_b = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready_b) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid_b = 1'b0;
    chk("b2b_accepts", 64'(acc), 64'd5);
    @(posedge clk); #1;
    chk("b2b_idle", 64'(req_ready_b), 64'd1);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0:       a = 64'h3F;
        1:       a = {1'b1, 31'($urandom), $urandom};
        2:       a = 64'(DEPTH + $urandom_range(0, 200));
        default: a = 64'($urandom_range(0, DEPTH - 1));
      endcase
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
